// File: rtl/perceptron_sample_feeder_if.sv
// Trainer-side handshake and sample bus between the sample feeder (master)
// and the perceptron training controller (slave).
interface perceptron_sample_feeder_if #(
    parameter int DATA_W = 8
);
    logic                     start;
    logic                     ready;
    logic                     ldcnt;
    logic                     ldx1;
    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] x2;
    logic signed [DATA_W-1:0] t;

    modport master (
        output start, x1, x2, t,
        input  ready, ldcnt, ldx1
    );

    modport slave (
        input  start, x1, x2, t,
        output ready, ldcnt, ldx1
    );
endinterface

// File: rtl/perceptron_sample_feeder.sv
// Host-side sample feeder for the perceptron trainer: holds the training set,
// issues the start pulse, serves samples round-robin and tracks epochs/errors.
module perceptron_sample_feeder #(
    parameter int DATA_W       = 8,
    parameter int NSAMP        = 4,
    parameter int AW           = 2,
    parameter int START_CYCLES = 2,
    parameter int EPOCH_MAX    = 255,
    parameter int EW           = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [DATA_W-1:0] wr_x1,
    input  logic signed [DATA_W-1:0] wr_x2,
    input  logic signed [DATA_W-1:0] wr_t,
    perceptron_sample_feeder_if.master tif,
    output logic                     busy,
    output logic                     done,
    output logic [EW-1:0]            epochs,
    output logic [15:0]              samples_fed,
    output logic                     overrun,
    output logic                     proto_err
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(NSAMP - 1);
    localparam logic [3:0]    START_END = 4'(START_CYCLES - 1);
    localparam logic [EW-1:0] EMAX      = EW'(EPOCH_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   idx_next;
    logic [3:0]      scnt;

    logic signed [DATA_W-1:0] mem_x1 [2**AW];
    logic signed [DATA_W-1:0] mem_x2 [2**AW];
    logic signed [DATA_W-1:0] mem_t  [2**AW];

    function automatic logic [EW-1:0] sat_inc_epochs(input logic [EW-1:0] v);
        return (v >= EMAX) ? v : v + 1'b1;
    endfunction

    // Sample pointer for the next cycle; ldcnt takes priority over ldx1.
    always_comb begin
        idx_next = idx;
        case (state)
            S_IDLE: if (go) idx_next = '0;
            S_RUN: begin
                if (tif.ldcnt)
                    idx_next = '0;
                else if (tif.ldx1)
                    idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            scnt        <= '0;
            tif.start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            epochs      <= '0;
            samples_fed <= '0;
            overrun     <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            idx  <= idx_next;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        epochs      <= '0;
                        samples_fed <= '0;
                        overrun     <= 1'b0;
                        proto_err   <= 1'b0;
                        scnt        <= '0;
                        tif.start   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    scnt <= scnt + 4'd1;
                    if (scnt == START_END) begin
                        tif.start <= 1'b0;
                        state     <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!tif.ready) state <= S_RUN;
                end
                S_RUN: begin
                    if (tif.ldcnt) begin
                        epochs <= sat_inc_epochs(epochs);
                        if (sat_inc_epochs(epochs) == EMAX) overrun <= 1'b1;
                        if (tif.ldx1) proto_err <= 1'b1;
                    end else if (tif.ldx1) begin
                        samples_fed <= samples_fed + 16'd1;
                    end
                    if (tif.ready) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!go) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Strobes are only legal while the trainer is running; this overrides the clear on go.
            if (state != S_RUN && (tif.ldx1 || tif.ldcnt)) proto_err <= 1'b1;
        end
    end

    // Training-set RAM: host writes only while the trainer is not using it.
    always_ff @(posedge clk) begin
        if (wr_en && (state == S_IDLE || state == S_DONE)) begin
            mem_x1[wr_addr] <= wr_x1;
            mem_x2[wr_addr] <= wr_x2;
            mem_t[wr_addr]  <= wr_t;
        end
    end

    // Output stage: registered from idx_next so the sample matches idx at any ldx1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tif.x1 <= '0;
            tif.x2 <= '0;
            tif.t  <= '0;
        end else begin
            tif.x1 <= mem_x1[idx_next];
            tif.x2 <= mem_x2[idx_next];
            tif.t  <= mem_t[idx_next];
        end
    end

endmodule

// File: tb/tb_perceptron_sample_feeder.sv
// Self-checking bench for perceptron_sample_feeder: plays the trainer side and
// checks served samples against a scoreboard built from a model of the RAM.
module tb_perceptron_sample_feeder;
    localparam int DATA_W       = 8;
    localparam int NSAMP        = 4;
    localparam int AW           = 2;
    localparam int START_CYCLES = 2;
    localparam int EPOCH_MAX    = 3;
    localparam int EW           = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     go;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic signed [DATA_W-1:0] wr_x1, wr_x2, wr_t;
    logic                     busy, done, overrun, proto_err;
    logic [EW-1:0]            epochs;
    logic [15:0]              samples_fed;

    perceptron_sample_feeder_if #(.DATA_W(DATA_W)) tif();

    perceptron_sample_feeder #(
        .DATA_W(DATA_W), .NSAMP(NSAMP), .AW(AW),
        .START_CYCLES(START_CYCLES), .EPOCH_MAX(EPOCH_MAX), .EW(EW)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t), .tif(tif),
        .busy(busy), .done(done), .epochs(epochs), .samples_fed(samples_fed),
        .overrun(overrun), .proto_err(proto_err)
    );

    typedef struct packed {
        logic signed [DATA_W-1:0] x1;
        logic signed [DATA_W-1:0] x2;
        logic signed [DATA_W-1:0] t;
    } samp_t;

    samp_t sb_q[$];
    samp_t m_ram[NSAMP];
    int    m_idx, m_fed, m_epochs;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trainer load: expected sample queued when ldx1 is raised, compared while it is high.
    task automatic serve_ldx1(input string tag);
        samp_t e, a;
        sb_q.push_back(m_ram[m_idx]);
        tif.ldx1 = 1'b1;
        a = '{x1: tif.x1, x2: tif.x2, t: tif.t};
        e = sb_q.pop_front();
        n_checks++;
        if (a !== e)
            $display("FAIL %s: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", tag,
                     a.x1, a.x2, a.t, e.x1, e.x2, e.t);
        else
            n_pass++;
        m_idx = (m_idx == NSAMP - 1) ? 0 : m_idx + 1;
        m_fed++;
        tick();
        tif.ldx1 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic serve_ldcnt();
        tif.ldcnt = 1'b1;
        m_idx = 0;
        m_epochs = (m_epochs >= EPOCH_MAX) ? EPOCH_MAX : m_epochs + 1;
        tick();
        tif.ldcnt = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({tif.start, busy, done, overrun, proto_err} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {tif.start, busy, done, overrun, proto_err});
        else n_pass++;
        n_checks++;
        if (epochs !== '0 || samples_fed !== 16'd0)
            $display("FAIL reset_counts: got epochs=%0d fed=%0d want 0/0", epochs, samples_fed);
        else n_pass++;
        n_checks++;
        if ({tif.x1, tif.x2, tif.t} !== '0)
            $display("FAIL reset_data: got (%0d,%0d,%0d) want 0", tif.x1, tif.x2, tif.t);
        else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic load_ram();
        int tx1[NSAMP] = '{1, 3, 5, -7};
        int tx2[NSAMP] = '{2, -4, 6, 8};
        int tt[NSAMP]  = '{1, -1, 1, -1};
        for (int i = 0; i < NSAMP; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_x1   = DATA_W'(tx1[i]);
            wr_x2   = DATA_W'(tx2[i]);
            wr_t    = DATA_W'(tt[i]);
            m_ram[i] = '{x1: wr_x1, x2: wr_x2, t: wr_t};
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid_start();
        go = 1'b1;
        tick();
        go = 1'b0;
        n_checks++;
        if (tif.start !== 1'b1) $display("FAIL mid_start_pre: got start=%b want 1", tif.start);
        else n_pass++;
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if ({tif.start, busy} !== 2'b00 || epochs !== '0)
            $display("FAIL mid_start_reset: got start=%b busy=%b epochs=%0d want 0,0,0",
                     tif.start, busy, epochs);
        else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({tif.x1, tif.x2, tif.t} !== m_ram[0])
            $display("FAIL ram_retained: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     tif.x1, tif.x2, tif.t, m_ram[0].x1, m_ram[0].x2, m_ram[0].t);
        else n_pass++;
    endtask

    task automatic test_handshake();
        int hi = 0;
        tif.ready = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        m_idx = 0; m_fed = 0; m_epochs = 0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", busy);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (tif.start === 1'b1) hi++;
            tick();
        end
        n_checks++;
        if (hi !== START_CYCLES) $display("FAIL start_width: got %0d want %0d", hi, START_CYCLES);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1 || tif.start !== 1'b0)
            $display("FAIL wait_busy: got busy=%b start=%b want 1,0", busy, tif.start);
        else n_pass++;
        tif.ready = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({busy, done, proto_err} !== 3'b100)
            $display("FAIL run_entry: got busy/done/err=%b want 100", {busy, done, proto_err});
        else n_pass++;
    endtask

    task automatic test_sample_order();
        for (int i = 0; i < 6; i++) serve_ldx1("sample_order");
        n_checks++;
        if (samples_fed !== 16'(m_fed))
            $display("FAIL samples_fed: got %0d want %0d", samples_fed, m_fed);
        else n_pass++;
        n_checks++;
        if (proto_err !== 1'b0) $display("FAIL order_proto: got %b want 0", proto_err);
        else n_pass++;
    endtask

    task automatic test_epoch_restart();
        serve_ldx1("pre_epoch");
        serve_ldx1("pre_epoch");
        serve_ldcnt();
        n_checks++;
        if (epochs !== EW'(m_epochs)) $display("FAIL epochs_1: got %0d want %0d", epochs, m_epochs);
        else n_pass++;
        serve_ldx1("post_epoch");
        serve_ldcnt();
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL overrun_early: got %b want 0", overrun);
        else n_pass++;
        serve_ldcnt();
        n_checks++;
        if (epochs !== EW'(m_epochs) || overrun !== 1'b1)
            $display("FAIL overrun_set: got epochs=%0d ovr=%b want %0d,1", epochs, overrun, m_epochs);
        else n_pass++;
        serve_ldcnt();
        n_checks++;
        if (epochs !== EW'(EPOCH_MAX)) $display("FAIL epochs_sat: got %0d want %0d", epochs, EPOCH_MAX);
        else n_pass++;
        n_checks++;
        if (samples_fed !== 16'(m_fed))
            $display("FAIL fed_after_epochs: got %0d want %0d", samples_fed, m_fed);
        else n_pass++;
    endtask

    task automatic test_run_write_ignored();
        wr_en = 1'b1; wr_addr = AW'(m_idx);
        wr_x1 = 8'sd99; wr_x2 = 8'sd99; wr_t = 8'sd99;
        tick();
        wr_en = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({tif.x1, tif.x2, tif.t} !== m_ram[m_idx])
            $display("FAIL run_write: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", tif.x1, tif.x2, tif.t,
                     m_ram[m_idx].x1, m_ram[m_idx].x2, m_ram[m_idx].t);
        else n_pass++;
    endtask

    task automatic test_completion();
        int pulses = 0;
        go = 1'b1;
        tif.ready = 1'b1;
        tick();
        n_checks++;
        if ({done, busy} !== 2'b10) $display("FAIL done_entry: got done/busy=%b want 10", {done, busy});
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL done_hold: got %0d active cycles want 0", pulses);
        else n_pass++;
        n_checks++;
        if (epochs !== EW'(EPOCH_MAX)) $display("FAIL done_results: got epochs=%0d want %0d", epochs, EPOCH_MAX);
        else n_pass++;
        go = 1'b0;
        tick();
    endtask

    task automatic test_protocol();
        tif.ldx1 = 1'b1;
        tick();
        tif.ldx1 = 1'b0;
        n_checks++;
        if (proto_err !== 1'b1) $display("FAIL idle_ldx1_err: got %b want 1", proto_err);
        else n_pass++;
        tick();
        n_checks++;
        if ({tif.x1, tif.x2, tif.t} !== m_ram[m_idx])
            $display("FAIL idle_idx_kept: got x1=%0d want %0d", tif.x1, m_ram[m_idx].x1);
        else n_pass++;
        wr_en = 1'b1; wr_addr = AW'(m_idx);
        wr_x1 = 8'sd10; wr_x2 = -8'sd10; wr_t = 8'sd1;
        m_ram[m_idx] = '{x1: wr_x1, x2: wr_x2, t: wr_t};
        tick();
        wr_en = 1'b0;
        tick();
        n_checks++;
        if ({tif.x1, tif.x2, tif.t} !== m_ram[m_idx])
            $display("FAIL idle_write: got (%0d,%0d,%0d) want (10,-10,1)", tif.x1, tif.x2, tif.t);
        else n_pass++;
        go = 1'b1;
        tick();
        go = 1'b0;
        m_idx = 0; m_fed = 0; m_epochs = 0;
        n_checks++;
        if (proto_err !== 1'b0 || epochs !== '0 || samples_fed !== 16'd0 || overrun !== 1'b0)
            $display("FAIL go_clears: got err=%b ep=%0d fed=%0d ovr=%b want 0", proto_err, epochs,
                     samples_fed, overrun);
        else n_pass++;
        repeat (4) tick();
        tif.ready = 1'b0;
        repeat (2) tick();
        serve_ldx1("proto_first");
        tif.ldx1 = 1'b1;
        tif.ldcnt = 1'b1;
        m_idx = 0;
        m_epochs = 1;
        tick();
        tif.ldx1 = 1'b0;
        tif.ldcnt = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (proto_err !== 1'b1 || epochs !== EW'(m_epochs))
            $display("FAIL both_strobes: got err=%b ep=%0d want 1,%0d", proto_err, epochs, m_epochs);
        else n_pass++;
        serve_ldx1("after_both");
        tif.ready = 1'b1;
        tick();
        n_checks++;
        if (done !== 1'b1) $display("FAIL final_done: got %b want 1", done);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_x1 = '0; wr_x2 = '0; wr_t = '0;
        tif.ready = 1'b1; tif.ldcnt = 1'b0; tif.ldx1 = 1'b0;
        m_idx = 0; m_fed = 0; m_epochs = 0;
        test_reset();
        load_ram();
        test_reset_mid_start();
        test_handshake();
        test_sample_order();
        test_epoch_restart();
        test_run_write_ignored();
        test_completion();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
